// File: rtl/calc_key_decoder_if.sv
// Key, ALU request/result and display signals of the calculator key decoder.
// master is the decoder side, slave is the grid/ALU/display environment side.
interface calc_key_decoder_if #(
  parameter int WIDTH = 16
);
  logic             key_valid;
  logic [4:0]       key_val;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_code;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] disp_val;
  logic             busy;

  modport master (
    input  key_valid, key_val, op_ready, res_valid, res_data,
    output op_valid, op_a, op_b, op_code, disp_val, busy
  );

  modport slave (
    output key_valid, key_val, op_ready, res_valid, res_data,
    input  op_valid, op_a, op_b, op_code, disp_val, busy
  );
endinterface

// File: rtl/calc_key_decoder.sv
// Calculator key decoder: assembles hex operands and an operator, issues them to the ALU.
// Optional macro CALC_KEY_DECODER_KEYBUF_EN adds a one-entry key buffer while busy.
module calc_key_decoder #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  calc_key_decoder_if.master bus
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_RES  = 3'd4
  } state_e;

  localparam logic [4:0] K_ADD  = 5'h10;
  localparam logic [4:0] K_MULT = 5'h11;
  localparam logic [4:0] K_AND  = 5'h12;
  localparam logic [4:0] K_EXE  = 5'h13;
  localparam logic [4:0] K_SUB  = 5'h14;
  localparam logic [4:0] K_OR   = 5'h15;
  localparam logic [4:0] K_CE   = 5'h16;
  localparam logic [4:0] K_CLR  = 5'h17;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [2:0]       op_q, op_d;
  logic             bEntered_q, bEntered_d;

  logic             busyState;
  logic             effValid;
  logic [4:0]       effCode;
  logic             isDigit;
  logic             isOper;
  logic [2:0]       operCode;
  logic [WIDTH-1:0] digitExt;

  assign busyState = (state_q == S_REQ) || (state_q == S_WAIT);

`ifdef CALC_KEY_DECODER_KEYBUF_EN
  logic       bufValid_q, bufValid_d;
  logic [4:0] bufCode_q, bufCode_d;

  // While busy the first meaningful key is parked; it replays in the first S_RES cycle,
  // and any key arriving in that same cycle loses to it.
  always_comb begin
    effValid   = 1'b0;
    effCode    = bus.key_val;
    bufValid_d = bufValid_q;
    bufCode_d  = bufCode_q;
    if (busyState) begin
      if (bus.key_valid && !bufValid_q && (bus.key_val < 5'h18)) begin
        bufValid_d = 1'b1;
        bufCode_d  = bus.key_val;
      end
    end else if ((state_q == S_RES) && bufValid_q) begin
      effValid   = 1'b1;
      effCode    = bufCode_q;
      bufValid_d = 1'b0;
    end else begin
      effValid = bus.key_valid;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bufValid_q <= 1'b0;
      bufCode_q  <= 5'd0;
    end else begin
      bufValid_q <= bufValid_d;
      bufCode_q  <= bufCode_d;
    end
  end
`else
  always_comb begin
    effValid = bus.key_valid && !busyState;
    effCode  = bus.key_val;
  end
`endif

  always_comb begin
    isOper   = 1'b1;
    operCode = OP_ADD;
    case (effCode)
      K_ADD:   operCode = OP_ADD;
      K_SUB:   operCode = OP_SUB;
      K_MULT:  operCode = OP_MULT;
      K_AND:   operCode = OP_AND;
      K_OR:    operCode = OP_OR;
      default: isOper   = 1'b0;
    endcase
  end

  assign isDigit  = ~effCode[4];
  assign digitExt = {{(WIDTH-4){1'b0}}, effCode[3:0]};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    op_d       = op_q;
    bEntered_d = bEntered_q;

    if (effValid && !busyState && (effCode == K_CLR)) begin
      a_d        = '0;
      b_d        = '0;
      r_d        = '0;
      op_d       = OP_ADD;
      bEntered_d = 1'b0;
      state_d    = S_A;
    end else begin
      case (state_q)
        S_A: begin
          if (effValid) begin
            if (isDigit) begin
              a_d = {a_q[WIDTH-5:0], effCode[3:0]};
            end else if (isOper) begin
              op_d       = operCode;
              b_d        = '0;
              bEntered_d = 1'b0;
              state_d    = S_B;
            end else if (effCode == K_CE) begin
              a_d = '0;
            end
          end
        end

        S_B: begin
          if (effValid) begin
            if (isDigit) begin
              b_d        = {b_q[WIDTH-5:0], effCode[3:0]};
              bEntered_d = 1'b1;
            end else if (isOper) begin
              // Operator only replaces the pending one until B has a digit.
              if (!bEntered_q) begin
                op_d = operCode;
              end
            end else if (effCode == K_EXE) begin
              state_d = S_REQ;
            end else if (effCode == K_CE) begin
              b_d        = '0;
              bEntered_d = 1'b0;
            end
          end
        end

        S_REQ: begin
          if (bus.op_ready) begin
            state_d = S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.res_valid) begin
            r_d     = bus.res_data;
            state_d = S_RES;
          end
        end

        S_RES: begin
          if (effValid) begin
            if (isDigit) begin
              a_d     = digitExt;
              b_d     = '0;
              state_d = S_A;
            end else if (isOper) begin
              // Chaining: the shown result becomes the next left operand.
              a_d        = r_q;
              op_d       = operCode;
              b_d        = '0;
              bEntered_d = 1'b0;
              state_d    = S_B;
            end else if (effCode == K_CE) begin
              r_d     = '0;
              a_d     = '0;
              state_d = S_A;
            end
          end
        end

        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      op_q       <= OP_ADD;
      bEntered_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      op_q       <= op_d;
      bEntered_q <= bEntered_d;
    end
  end

  always_comb begin
    bus.disp_val = a_q;
    case (state_q)
      S_A:          bus.disp_val = a_q;
      S_B:          bus.disp_val = bEntered_q ? b_q : a_q;
      S_REQ, S_WAIT: bus.disp_val = b_q;
      S_RES:        bus.disp_val = r_q;
      default:      bus.disp_val = a_q;
    endcase
  end

  assign bus.op_valid = (state_q == S_REQ);
  assign bus.busy     = busyState;
  assign bus.op_a     = a_q;
  assign bus.op_b     = b_q;
  assign bus.op_code  = op_q;

endmodule

// File: tb/tb_calc_key_decoder.sv
// Directed self-checking bench for calc_key_decoder (WIDTH = 16).
module tb_calc_key_decoder;

  logic clk;
  logic rstN;
  int   testCount;
  int   failCount;

  calc_key_decoder_if #(.WIDTH(16)) bus ();

  calc_key_decoder #(.WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] K_ADD  = 5'h10;
  localparam logic [4:0] K_MULT = 5'h11;
  localparam logic [4:0] K_EXE  = 5'h13;
  localparam logic [4:0] K_SUB  = 5'h14;
  localparam logic [4:0] K_OR   = 5'h15;
  localparam logic [4:0] K_CE   = 5'h16;
  localparam logic [4:0] K_CLR  = 5'h17;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressKey(input logic [4:0] code);
    bus.key_valid = 1'b1;
    bus.key_val   = code;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic completeOp(input logic [15:0] result);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b1;
    bus.res_data  = result;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    testCount++;
    if ({bus.op_valid, bus.busy, bus.op_code} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {bus.op_valid, bus.busy, bus.op_code});
    end
    testCount++;
    if ({bus.disp_val, bus.op_a, bus.op_b} !== 48'h0) begin
      failCount++;
      $display("[TB] FAIL reset_data: got %h expected 0", {bus.disp_val, bus.op_a, bus.op_b});
    end
    @(negedge clk);
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_add_flow();
    pressKey(5'h1);
    pressKey(5'h2);
    testCount++;
    if (bus.disp_val !== 16'h0012) begin
      failCount++;
      $display("[TB] FAIL add_digits: got %h expected 0012", bus.disp_val);
    end
    pressKey(K_ADD);
    pressKey(5'h3);
    pressKey(K_EXE);
    testCount++;
    if ({bus.op_valid, bus.busy, bus.op_a, bus.op_b, bus.op_code} !== {1'b1, 1'b1, 16'h0012, 16'h0003, 3'd0}) begin
      failCount++;
      $display("[TB] FAIL add_request: got v=%b busy=%b a=%h b=%h op=%0d expected v=1 busy=1 a=0012 b=0003 op=0",
               bus.op_valid, bus.busy, bus.op_a, bus.op_b, bus.op_code);
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    testCount++;
    if ({bus.op_valid, bus.busy} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL add_wait: got v=%b busy=%b expected v=0 busy=1", bus.op_valid, bus.busy);
    end
    bus.res_valid = 1'b1;
    bus.res_data  = 16'h0015;
    tick();
    bus.res_valid = 1'b0;
    testCount++;
    if ({bus.disp_val, bus.busy} !== {16'h0015, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL add_result: got disp=%h busy=%b expected disp=0015 busy=0", bus.disp_val, bus.busy);
    end
    bus.res_valid = 1'b1;
    bus.res_data  = 16'hBEEF;
    tick();
    bus.res_valid = 1'b0;
    testCount++;
    if (bus.disp_val !== 16'h0015) begin
      failCount++;
      $display("[TB] FAIL stray_result: got %h expected 0015", bus.disp_val);
    end
  endtask

  task automatic test_digit_shift();
    logic [4:0]  digs [5];
    logic [15:0] expSeq [5];
    digs   = '{5'hA, 5'hB, 5'hC, 5'hD, 5'hE};
    expSeq = '{16'h000A, 16'h00AB, 16'h0ABC, 16'hABCD, 16'hBCDE};
    pressKey(K_CLR);
    testCount++;
    if (bus.disp_val !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL clr_from_res: got %h expected 0000", bus.disp_val);
    end
    for (int i = 0; i < 5; i++) begin
      pressKey(digs[i]);
      testCount++;
      if (bus.disp_val !== expSeq[i]) begin
        failCount++;
        $display("[TB] FAIL digit_shift_%0d: got %h expected %h", i, bus.disp_val, expSeq[i]);
      end
    end
    pressKey(5'h1C);
    testCount++;
    if ({bus.disp_val, bus.busy} !== {16'hBCDE, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL ignored_code: got %h expected BCDE", bus.disp_val);
    end
  endtask

  task automatic test_operator_replace();
    pressKey(K_CLR);
    pressKey(5'h5);
    pressKey(K_ADD);
    pressKey(K_SUB);
    testCount++;
    if (bus.disp_val !== 16'h0005) begin
      failCount++;
      $display("[TB] FAIL oper_shows_a: got %h expected 0005", bus.disp_val);
    end
    pressKey(5'h7);
    pressKey(K_MULT);
    testCount++;
    if (bus.disp_val !== 16'h0007) begin
      failCount++;
      $display("[TB] FAIL oper_ignored_disp: got %h expected 0007", bus.disp_val);
    end
    pressKey(K_EXE);
    testCount++;
    if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_code} !== {1'b1, 16'h0005, 16'h0007, 3'd1}) begin
      failCount++;
      $display("[TB] FAIL oper_replace: got v=%b a=%h b=%h op=%0d expected v=1 a=0005 b=0007 op=1",
               bus.op_valid, bus.op_a, bus.op_b, bus.op_code);
    end
    completeOp(16'hFFFE);
  endtask

  task automatic test_ready_stall();
    pressKey(5'h4);
    testCount++;
    if (bus.disp_val !== 16'h0004) begin
      failCount++;
      $display("[TB] FAIL digit_from_res: got %h expected 0004", bus.disp_val);
    end
    pressKey(K_MULT);
    pressKey(5'h6);
    pressKey(K_EXE);
    for (int i = 0; i < 5; i++) begin
      testCount++;
      if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_code} !== {1'b1, 16'h0004, 16'h0006, 3'd2}) begin
        failCount++;
        $display("[TB] FAIL stall_hold_%0d: got v=%b a=%h b=%h op=%0d expected v=1 a=0004 b=0006 op=2",
                 i, bus.op_valid, bus.op_a, bus.op_b, bus.op_code);
      end
      if (i == 1) pressKey(5'h9);
      else if (i == 3) pressKey(5'h3);
      else tick();
    end
    bus.op_ready = 1'b1;
    testCount++;
    if (bus.op_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stall_ready_cycle: got %b expected 1", bus.op_valid);
    end
    tick();
    bus.op_ready = 1'b0;
    testCount++;
    if (bus.op_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL stall_drop: got %b expected 0", bus.op_valid);
    end
    pressKey(K_CLR);
    bus.res_valid = 1'b1;
    bus.res_data  = 16'h0018;
    tick();
    bus.res_valid = 1'b0;
    testCount++;
    if (bus.disp_val !== 16'h0018) begin
      failCount++;
      $display("[TB] FAIL stall_result: got %h expected 0018", bus.disp_val);
    end
    tick();
    testCount++;
`ifdef CALC_KEY_DECODER_KEYBUF_EN
    if (bus.disp_val !== 16'h0009) begin
      failCount++;
      $display("[TB] FAIL keybuf_replay: got %h expected 0009", bus.disp_val);
    end
`else
    if (bus.disp_val !== 16'h0018) begin
      failCount++;
      $display("[TB] FAIL busy_key_dropped: got %h expected 0018", bus.disp_val);
    end
`endif
  endtask

  task automatic test_back_to_back();
    pressKey(K_CLR);
    pressKey(5'hC);
    pressKey(K_ADD);
    pressKey(5'hC);
    pressKey(K_EXE);
    bus.op_ready  = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data  = 16'hDEAD;
    tick();
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    tick();
    testCount++;
    if ({bus.busy, bus.op_valid, bus.disp_val} !== {1'b1, 1'b0, 16'h000C}) begin
      failCount++;
      $display("[TB] FAIL same_cycle_res: got busy=%b v=%b disp=%h expected busy=1 v=0 disp=000C",
               bus.busy, bus.op_valid, bus.disp_val);
    end
    bus.res_valid = 1'b1;
    bus.res_data  = 16'h0018;
    tick();
    bus.res_valid = 1'b0;
    pressKey(K_ADD);
    testCount++;
    if (bus.disp_val !== 16'h0018) begin
      failCount++;
      $display("[TB] FAIL chain_shows_r: got %h expected 0018", bus.disp_val);
    end
    pressKey(5'h2);
    pressKey(K_EXE);
    testCount++;
    if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_code} !== {1'b1, 16'h0018, 16'h0002, 3'd0}) begin
      failCount++;
      $display("[TB] FAIL chain_request: got v=%b a=%h b=%h op=%0d expected v=1 a=0018 b=0002 op=0",
               bus.op_valid, bus.op_a, bus.op_b, bus.op_code);
    end
    completeOp(16'h001A);
    testCount++;
    if (bus.disp_val !== 16'h001A) begin
      failCount++;
      $display("[TB] FAIL chain_result: got %h expected 001A", bus.disp_val);
    end
    pressKey(K_CE);
    testCount++;
    if ({bus.disp_val, bus.busy} !== {16'h0000, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL ce_in_res: got disp=%h busy=%b expected disp=0000 busy=0", bus.disp_val, bus.busy);
    end
    pressKey(K_EXE);
    testCount++;
    if (bus.op_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL exe_in_a: got %b expected 0", bus.op_valid);
    end
  endtask

  task automatic test_ce_keeps_op();
    pressKey(5'h2);
    pressKey(K_SUB);
    pressKey(5'h9);
    pressKey(K_CE);
    testCount++;
    if (bus.disp_val !== 16'h0002) begin
      failCount++;
      $display("[TB] FAIL ce_in_b: got %h expected 0002", bus.disp_val);
    end
    pressKey(5'h1);
    pressKey(K_EXE);
    testCount++;
    if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_code} !== {1'b1, 16'h0002, 16'h0001, 3'd1}) begin
      failCount++;
      $display("[TB] FAIL ce_keeps_op: got v=%b a=%h b=%h op=%0d expected v=1 a=0002 b=0001 op=1",
               bus.op_valid, bus.op_a, bus.op_b, bus.op_code);
    end
    completeOp(16'h0001);
  endtask

  task automatic test_clear_and_reset();
    pressKey(K_CLR);
    pressKey(5'h3);
    pressKey(K_ADD);
    pressKey(5'h4);
    testCount++;
    if (bus.disp_val !== 16'h0004) begin
      failCount++;
      $display("[TB] FAIL pre_clr: got %h expected 0004", bus.disp_val);
    end
    pressKey(K_CLR);
    testCount++;
    if (bus.disp_val !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL clr_disp: got %h expected 0000", bus.disp_val);
    end
    pressKey(5'h6);
    pressKey(K_OR);
    testCount++;
    if (bus.disp_val !== 16'h0006) begin
      failCount++;
      $display("[TB] FAIL clr_b_entered: got %h expected 0006", bus.disp_val);
    end
    pressKey(K_EXE);
    testCount++;
    if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_code} !== {1'b1, 16'h0006, 16'h0000, 3'd4}) begin
      failCount++;
      $display("[TB] FAIL exe_empty_b: got v=%b a=%h b=%h op=%0d expected v=1 a=0006 b=0000 op=4",
               bus.op_valid, bus.op_a, bus.op_b, bus.op_code);
    end
    #2;
    rstN = 1'b0;
    #1;
    testCount++;
    if ({bus.op_valid, bus.busy, bus.op_code, bus.disp_val, bus.op_a, bus.op_b} !== 53'h0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got v=%b busy=%b op=%0d disp=%h a=%h b=%h expected all zero",
               bus.op_valid, bus.busy, bus.op_code, bus.disp_val, bus.op_a, bus.op_b);
    end
    @(negedge clk);
    rstN = 1'b1;
    tick();
    pressKey(5'h7);
    testCount++;
    if ({bus.disp_val, bus.busy} !== {16'h0007, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL after_reset: got %h expected 0007", bus.disp_val);
    end
  endtask

  initial begin
    testCount     = 0;
    failCount     = 0;
    rstN          = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_val   = 5'd0;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = 16'h0;
    test_reset();
    test_add_flow();
    test_digit_shift();
    test_operator_replace();
    test_ready_stall();
    test_back_to_back();
    test_ce_keeps_op();
    test_clear_and_reset();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/calc_key_decoder.md
# calc_key_decoder

Consumes the 5-bit key codes produced by the calculator's on-screen cursor grid and turns them into a calculation. It assembles two hexadecimal operands and an operator, issues the operation to the downstream ALU over a valid/ready request followed by a result strobe, and drives the value shown on the display. It sits between the grid cursor/select logic and the ALU/display path.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and ≥ 8.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- key_valid  in  1  one-cycle strobe; key_val is consumed in this cycle. Held high means one key per cycle.
- key_val  in  5  key code: 0x00–0x0F hex digit; 0x10 ADD; 0x11 MULT; 0x12 AND; 0x13 EXE; 0x14 SUB; 0x15 OR; 0x16 CE; 0x17 CLR; 0x18–0x1F ignored.
- op_valid  out  1  operation request to the ALU.
- op_ready  in  1  ALU accepts the request when op_valid && op_ready.
- op_a, op_b  out  WIDTH  operands; stable while op_valid is high.
- op_code  out  3  0 ADD, 1 SUB, 2 MULT, 3 AND, 4 OR; stable while op_valid is high.
- res_valid  in  1  one-cycle result strobe from the ALU.
- res_data  in  WIDTH  result, sampled when res_valid is high.
- disp_val  out  WIDTH  value to display.
- busy  out  1  high in S_REQ and S_WAIT.

## Operation
- Registers: A, B, R (WIDTH each), OP (3), b_entered (1), state.
- FSM states: S_A (enter A), S_B (enter B), S_REQ (request pending), S_WAIT (awaiting result), S_RES (result shown).
- Digit d: target ← {target[WIDTH-5:0], d}. The most significant nibble is discarded, with no saturation. The target is A in S_A and B in S_B, and b_entered ← 1. In S_RES, a digit sets A ← {0, d}, B ← 0 and moves to S_A.
- Operator key: in S_A, OP ← code, B ← 0, b_entered ← 0, → S_B. In S_B with b_entered = 0, OP is replaced. In S_B with b_entered = 1, the key is ignored. In S_RES, A ← R, OP ← code, B ← 0, b_entered ← 0, → S_B.
- EXE: in S_B, → S_REQ, including when b_entered = 0, which uses B = 0. In S_A and S_RES it is ignored.
- CE: in S_A, A ← 0. In S_B, B ← 0 and b_entered ← 0, with OP kept. In S_RES, R ← 0, A ← 0, → S_A.
- CLR: A, B, R, OP, b_entered ← 0, → S_A.
- S_REQ: op_valid = 1 with op_a = A, op_b = B, op_code = OP. On op_ready → S_WAIT.
- S_WAIT: on res_valid, R ← res_data, → S_RES. A res_valid arriving in any other state is ignored.
- Keys in S_REQ/S_WAIT, including CLR, are dropped. See Configuration for the exception.
- disp_val: S_A shows A. S_B shows b_entered ? B : A. S_REQ/S_WAIT show B. S_RES shows R.
- Codes 0x18–0x1F: no effect in any state.

## Timing
- Reset (rst = 0, async): state = S_A; A = B = R = 0; OP = 0; b_entered = 0; op_valid = 0; busy = 0; disp_val = 0; op_a = op_b = 0; op_code = 0.
- Key effects are registered: key in cycle n is visible on disp_val/state in cycle n+1.
- EXE in cycle n → op_valid high from cycle n+1. op_valid stays high until the op_ready cycle inclusive, then falls the next cycle.
- op_ready and res_valid in the same cycle in S_REQ: the handshake completes and res_valid is ignored. The ALU must deliver the result at least one cycle after acceptance.
- Minimum EXE-to-result-display latency: 3 cycles, for op_ready high in S_REQ entry cycle and res_valid on the next cycle.
- Reset assertion mid-handshake drops op_valid immediately (async). The ALU must tolerate an abandoned request.

## Configuration
- CALC_KEY_DECODER_KEYBUF_EN defined: adds a one-entry key buffer. The first key arriving in S_REQ/S_WAIT is stored, and later ones are dropped. It is processed in the first cycle in S_RES, as if it arrived then. A new key_valid in that same cycle is dropped. Reset clears the buffer.
- Not defined: no buffer; all keys in S_REQ/S_WAIT are dropped.

## Test plan
- Keys 1,2,ADD,3,EXE; op_ready=1 immediately; res_valid with 0x0015 one cycle later → op_a=0x0012, op_b=0x0003, op_code=0; disp_val=0x0015 in S_RES.
- Digits A,B,C,D,E (WIDTH=16) → disp_val sequence 0x000A, 0x00AB, 0x0ABC, 0xABCD, 0xBCDE.
- 5,ADD,SUB,7,MULT,EXE → op_code=1 (SUB) and op_b=0x0007; the MULT is ignored.
- 4,MULT,6,EXE with op_ready low for 5 cycles → op_valid held 6 cycles, operands stable; key 9 sent during the wait is dropped (buffered and shown as 0x0009 after the result if KEYBUF_EN).
- After result 0x0018 shown: ADD,2,EXE → op_a=0x0018, op_b=0x0002; then CE → disp_val=0, state S_A.
- 3,ADD,4 then CLR → disp_val=0, b_entered=0; rst pulse low in S_REQ → op_valid=0 at once, all outputs at reset values.
